// File: rtl/sdcard_streamer_if.sv
// sdcard_streamer_if
// Client-side bundle for the sector streamer: the request channel, the
// 512-byte read stream, the 512-byte write stream and the status flags.
//   master : the request issuer / stream endpoint (bridge, DMA, bench)
//   slave  : the streamer itself
// Signals:
//   req_valid/req_ready/req_write/req_sector : sector request handshake
//   m_data/m_valid/m_ready                   : read byte stream out of the streamer
//   s_data/s_valid/s_ready                   : write byte stream into the streamer
//   done                                     : one-cycle completion pulse
//   timeout                                  : sticky busy-wait expiry flag
interface sdcard_streamer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_sector;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        done;
    logic        timeout;

    modport master (
        output req_valid, req_write, req_sector, m_ready, s_data, s_valid,
        input  req_ready, m_data, m_valid, s_ready, done, timeout
    );

    modport slave (
        input  req_valid, req_write, req_sector, m_ready, s_data, s_valid,
        output req_ready, m_data, m_valid, s_ready, done, timeout
    );
endinterface

// File: rtl/sdcard_streamer.sv
// sdcard_streamer
// Converts whole-sector read/write requests into command sequences for the
// downstream sdcard block. Reads are delivered as a 512-byte valid/ready
// stream, writes are collected from a 512-byte valid/ready stream.
// Ports:
//   clk            : system clock (shared with sdcard)
//   rst            : asynchronous active-high reset (also resets sdcard)
//   bus            : sdcard_streamer_if.slave (request, streams, done, timeout)
//   sd_command_o   : command to sdcard (0 idle,1 read,2 advance,3 buf write,4 write)
//   sd_sector_o    : registered sector number for sdcard
//   sd_data_in_o   : write byte to sdcard (copy of the write stream data)
//   sd_data_out_i  : read byte from sdcard (forwarded to the read stream)
//   sd_busy_i      : sdcard busy flag
module sdcard_streamer #(
    parameter int unsigned TimeoutCycles = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    sdcard_streamer_if.slave   bus,
    output logic [2:0]         sd_command_o,
    output logic [31:0]        sd_sector_o,
    output logic [7:0]         sd_data_in_o,
    input  logic [7:0]         sd_data_out_i,
    input  logic               sd_busy_i
);

    localparam logic [2:0] CmdIdle    = 3'd0;
    localparam logic [2:0] CmdRead    = 3'd1;
    localparam logic [2:0] CmdAdvance = 3'd2;
    localparam logic [2:0] CmdBufWr   = 3'd3;
    localparam logic [2:0] CmdWrite   = 3'd4;

    localparam logic [31:0] TimeoutLimit = 32'(TimeoutCycles);

    typedef enum logic [3:0] {
        Init,
        Idle,
        RdIssue,
        RdSettle,
        RdWait,
        RdStream,
        WrFill,
        WrIssue,
        WrSettle,
        WrWait,
        Done
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sector_q, sector_d;
    logic [8:0]  byte_count_q, byte_count_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= Init;
            sector_q     <= '0;
            byte_count_q <= '0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sector_q     <= sector_d;
            byte_count_q <= byte_count_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sector_d     = sector_q;
        byte_count_d = byte_count_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        sd_command_o = CmdIdle;
        bus.req_ready = 1'b0;
        bus.m_valid   = 1'b0;
        bus.s_ready   = 1'b0;
        bus.done      = 1'b0;

        unique case (state_q)
            Init: begin
                // sdcard may still be initialising after reset
                if (!sd_busy_i) state_d = Idle;
            end
            Idle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    sector_d     = bus.req_sector;
                    byte_count_d = '0;
                    state_d      = bus.req_write ? WrFill : RdIssue;
                end
            end
            RdIssue: begin
                sd_command_o = CmdRead;
                state_d      = RdSettle;
            end
            RdSettle: begin
                // busy only rises the cycle after the command; skip a cycle
                // so the wait state never sees a stale low busy
                wait_cnt_d = '0;
                state_d    = RdWait;
            end
            RdWait: begin
                wait_cnt_d = wait_cnt_q + 32'd1;
                if (wait_cnt_d == TimeoutLimit) timeout_d = 1'b1;
                if (!sd_busy_i) state_d = RdStream;
            end
            RdStream: begin
                bus.m_valid = 1'b1;
                if (bus.m_ready) begin
                    // advancing moves sdcard's index, so the next byte
                    // appears on sd_data_out in the following cycle
                    sd_command_o = CmdAdvance;
                    byte_count_d = byte_count_q + 9'd1;
                    if (byte_count_q == 9'd511) state_d = Done;
                end
            end
            WrFill: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    sd_command_o = CmdBufWr;
                    byte_count_d = byte_count_q + 9'd1;
                    if (byte_count_q == 9'd511) state_d = WrIssue;
                end
            end
            WrIssue: begin
                sd_command_o = CmdWrite;
                state_d      = WrSettle;
            end
            WrSettle: begin
                wait_cnt_d = '0;
                state_d    = WrWait;
            end
            WrWait: begin
                wait_cnt_d = wait_cnt_q + 32'd1;
                if (wait_cnt_d == TimeoutLimit) timeout_d = 1'b1;
                if (!sd_busy_i) state_d = Done;
            end
            Done: begin
                bus.done = 1'b1;
                state_d  = Idle;
            end
            default: state_d = Init;
        endcase
    end

    assign sd_sector_o  = sector_q;
    assign sd_data_in_o = bus.s_data;
    assign bus.m_data   = sd_data_out_i;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_sdcard_streamer.sv
module tb_sdcard_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sd_command;
    logic [31:0] sd_sector;
    logic [7:0]  sd_data_in;
    logic [7:0]  sd_data_out;
    logic        sd_busy;

    sdcard_streamer_if bus ();

    sdcard_streamer #(.TimeoutCycles(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .sd_command_o  (sd_command),
        .sd_sector_o   (sd_sector),
        .sd_data_in_o  (sd_data_in),
        .sd_data_out_i (sd_data_out),
        .sd_busy_i     (sd_busy)
    );

    always #5 clk = ~clk;

    // ---------------- sdcard behavioural model ----------------
    int          startup_busy = 100;
    int          busy_len     = 6;
    logic [7:0]  fill_key     = 8'h00;
    logic [7:0]  mem [512];
    logic [8:0]  idx;
    int          busy_ctr;
    int          n1 = 0, n2 = 0, n3 = 0, n4 = 0;
    logic [31:0] last_sec = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            busy_ctr <= startup_busy;
        end else if (busy_ctr != 0) begin
            busy_ctr <= busy_ctr - 1;
        end else begin
            case (sd_command)
                3'd1: begin
                    n1       <= n1 + 1;
                    last_sec <= sd_sector;
                    busy_ctr <= busy_len;
                    idx      <= '0;
                    for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ fill_key;
                end
                3'd2: begin
                    n2  <= n2 + 1;
                    idx <= idx + 9'd1;
                end
                3'd3: begin
                    n3       <= n3 + 1;
                    mem[idx] <= sd_data_in;
                    idx      <= idx + 9'd1;
                end
                3'd4: begin
                    n4       <= n4 + 1;
                    last_sec <= sd_sector;
                    busy_ctr <= busy_len;
                    idx      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign sd_busy     = (busy_ctr != 0);
    assign sd_data_out = mem[idx];

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %-22s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %-22s got %0h", tag, got);
        end
    endtask

    task automatic send_req(input logic wr, input logic [31:0] sec);
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_sector = sec;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
    endtask

    // Collects up to stop_after read bytes, comparing each with i^key.
    task automatic collect_read(input logic rnd, input int stop_after, input logic [7:0] key,
                                output int got, output int bad, output int early_done);
        got = 0; bad = 0; early_done = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.done) early_done++;
            if (bus.m_valid && bus.m_ready) begin
                if (bus.m_data !== (8'(got) ^ key)) bad++;
                got++;
                if (got == stop_after) begin
                    @(posedge clk);
                    #1;
                    break;
                end
            end
        end
        bus.m_ready = 1'b0;
    endtask

    task automatic finish_read(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
        chk({tag, "_ready_again"}, 32'(bus.req_ready), 32'd1);
    endtask

    int got, bad, early, s1, s2, s3, s4, cyc, early_rdy;
    logic prev_busy;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_sector = '0;
        bus.m_ready    = 1'b0;
        bus.s_data     = '0;
        bus.s_valid    = 1'b0;

        // ---- reset state and startup gating ----
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_sd_command", 32'(sd_command), 32'd0);
        chk("rst_sd_sector", sd_sector, 32'd0);
        rst = 1'b0;
        cyc = 0; early_rdy = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready) early_rdy++;
            if (!sd_busy) break;
        end
        chk("startup_busy_len", cyc, 32'd100);
        chk("startup_no_early_rdy", early_rdy, 32'd0);
        @(negedge clk);
        chk("startup_ready", 32'(bus.req_ready), 32'd1);

        // ---- read sector 5, m_ready held ----
        busy_len = 6; fill_key = 8'hA5;
        s1 = n1; s2 = n2;
        send_req(1'b0, 32'd5);
        collect_read(1'b0, 512, 8'hA5, got, bad, early);
        chk("rd_byte_count", got, 32'd512);
        chk("rd_byte_errors", bad, 32'd0);
        chk("rd_early_done", early, 32'd0);
        finish_read("rd");
        chk("rd_cmd1_count", n1 - s1, 32'd1);
        chk("rd_cmd1_sector", last_sec, 32'd5);
        chk("rd_cmd2_count", n2 - s2, 32'd512);

        // ---- read with random backpressure ----
        fill_key = 8'h96;
        s2 = n2;
        send_req(1'b0, 32'h1234_5678);
        collect_read(1'b1, 512, 8'h96, got, bad, early);
        chk("bp_byte_count", got, 32'd512);
        chk("bp_byte_errors", bad, 32'd0);
        finish_read("bp");
        chk("bp_cmd2_count", n2 - s2, 32'd512);
        chk("bp_sector", last_sec, 32'h1234_5678);

        // ---- write sector 0xFFFF_FFFF, gapped s_valid ----
        s3 = n3; s4 = n4; got = 0;
        send_req(1'b1, 32'hFFFF_FFFF);
        for (int j = 0; j < 3000; j++) begin
            @(negedge clk);
            bus.s_valid = (j % 4 != 2);
            bus.s_data  = 8'(got);
            #1;
            if (bus.s_valid && bus.s_ready) begin
                got++;
                if (got == 512) begin
                    @(posedge clk);
                    #1;
                    break;
                end
            end
        end
        bus.s_valid = 1'b0;
        chk("wr_byte_count", got, 32'd512);
        @(negedge clk);
        chk("wr_cmd4_next_cycle", 32'(sd_command), 32'd4);
        chk("wr_cmd3_count", n3 - s3, 32'd512);
        prev_busy = 1'b1;
        for (int k = 0; k < 200; k++) begin
            prev_busy = sd_busy;
            @(negedge clk);
            if (bus.done) break;
        end
        chk("wr_done_seen", 32'(bus.done), 32'd1);
        chk("wr_done_after_busy", 32'(prev_busy), 32'd0);
        chk("wr_cmd4_count", n4 - s4, 32'd1);
        chk("wr_sector", last_sec, 32'hFFFF_FFFF);
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== 8'(i)) bad++;
        chk("wr_buffer_errors", bad, 32'd0);
        chk("wr_timeout_clear", 32'(bus.timeout), 32'd0);

        // ---- reset mid-stream, then read sector 7 ----
        fill_key = 8'h3C; startup_busy = 5;
        send_req(1'b0, 32'd9);
        collect_read(1'b0, 200, 8'h3C, got, bad, early);
        chk("mid_bytes_before_rst", got, 32'd200);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_rst_sd_command", 32'(sd_command), 32'd0);
        chk("mid_rst_sd_sector", sd_sector, 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fill_key = 8'h5A;
        send_req(1'b0, 32'd7);
        collect_read(1'b0, 512, 8'h5A, got, bad, early);
        chk("mid_new_byte_count", got, 32'd512);
        chk("mid_new_byte_errors", bad, 32'd0);
        chk("mid_new_sector", last_sec, 32'd7);
        finish_read("mid");

        // ---- timeout with busy stuck long after command 1 ----
        busy_len = 40; fill_key = 8'h33;
        send_req(1'b0, 32'h0000_0ABC);
        early = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done) early++;
            if (k == 8) chk("to_not_yet", 32'(bus.timeout), 32'd0);
        end
        chk("to_set", 32'(bus.timeout), 32'd1);
        collect_read(1'b0, 512, 8'h33, got, bad, early);
        chk("to_byte_count", got, 32'd512);
        chk("to_byte_errors", bad, 32'd0);
        chk("to_no_done_in_wait", early, 32'd0);
        finish_read("to");
        chk("to_sticky", 32'(bus.timeout), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
